// File: rtl/bch_31_encoder.sv
// Systematic BCH(31,21) t=2 encoder, LFSR divider over g(x); BCH_ENC_ERR_INJECT_EN adds err_mask XOR on the codeword.
// Latency: accept edge t0 -> out_valid after edge t0+L, L = 21/BITS_PER_CYCLE.
// Backpressure: one message in flight; in_ready low in ENCODE/HOLD, codeword held until out_ready.
module bch_31_encoder #(
  parameter int          BITS_PER_CYCLE = 1,
  parameter logic [10:0] GEN_POLY       = 11'h769
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [20:0] message,
`ifdef BCH_ENC_ERR_INJECT_EN
  input  logic [30:0] err_mask,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [30:0] codeword,
  output logic        busy
);

  localparam int L     = 21 / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(L + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(L - 1);

  generate
    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 3 ||
          BITS_PER_CYCLE == 7 || BITS_PER_CYCLE == 21)) begin : g_bad_bpc
      $error("bch_31_encoder: BITS_PER_CYCLE must be 1, 3, 7 or 21");
    end
    if (GEN_POLY[10] != 1'b1) begin : g_bad_poly
      $error("bch_31_encoder: GEN_POLY must be degree 10");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 armed_q;
  logic [20:0]          msg_q;
  logic [20:0]          sh_q;
  logic [9:0]           lfsr_q;
  logic [9:0]           lfsr_next;
  logic [CNT_W-1:0]     cnt_q;
  logic [30:0]          cw_q;
  logic [30:0]          mask_in;
  logic [30:0]          mask_q;
  logic                 accept;
  logic                 enc_last;

`ifdef BCH_ENC_ERR_INJECT_EN
  assign mask_in = err_mask;
`else
  assign mask_in = '0;
`endif

  // One GF(2) division step per message bit, MSB of the slice first.
  function automatic logic [9:0] lfsr_step(input logic [9:0]                s,
                                           input logic [BITS_PER_CYCLE-1:0] bits);
    logic [9:0] r;
    logic       fb;
    r = s;
    for (int k = BITS_PER_CYCLE - 1; k >= 0; k--) begin
      fb = bits[k] ^ r[9];
      r  = {r[8:0], 1'b0} ^ (fb ? GEN_POLY[9:0] : 10'd0);
    end
    return r;
  endfunction

  assign lfsr_next = lfsr_step(lfsr_q, sh_q[20 -: BITS_PER_CYCLE]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    enc_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed_q && in_valid) begin
          accept  = 1'b1;
          state_d = ENCODE;
        end
      end
      ENCODE: begin
        if (cnt_q == CNT_LAST) begin
          enc_last = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // armed_q keeps in_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q <= 1'b0;
      msg_q   <= '0;
      sh_q    <= '0;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      cw_q    <= '0;
      mask_q  <= '0;
    end else begin
      armed_q <= 1'b1;
      if (accept) begin
        msg_q  <= message;
        sh_q   <= message;
        lfsr_q <= '0;
        cnt_q  <= '0;
        mask_q <= mask_in;
      end else if (state_q == ENCODE) begin
        sh_q   <= sh_q << BITS_PER_CYCLE;
        lfsr_q <= lfsr_next;
        cnt_q  <= cnt_q + CNT_W'(1);
        if (enc_last) begin
          cw_q <= {msg_q, lfsr_next} ^ mask_q;
        end
      end
    end
  end

  assign in_ready  = armed_q && (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign codeword  = cw_q;

endmodule

// File: tb/tb_bch_31_encoder.sv
// Runs four encoders (1/3/7/21 bits per cycle) in parallel against a polynomial-division model.
module tb_bch_31_encoder;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [20:0] message = '0;
  logic [30:0] err_mask = '0;

  logic        in_ready_a  [N];
  logic        out_valid_a [N];
  logic        busy_a      [N];
  logic [30:0] codeword_a  [N];

  int total = 0;
  int bad   = 0;
  int ordy_mode = 2;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_dut
      localparam int B = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 7 : 21;
      bch_31_encoder #(.BITS_PER_CYCLE(B), .GEN_POLY(11'h769)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a[g]),
        .message   (message),
`ifdef BCH_ENC_ERR_INJECT_EN
        .err_mask  (err_mask),
`endif
        .out_valid (out_valid_a[g]),
        .out_ready (out_ready),
        .codeword  (codeword_a[g]),
        .busy      (busy_a[g])
      );
    end
  endgenerate

  function automatic int bpc(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      2:       return 7;
      default: return 21;
    endcase
  endfunction

  // Long division of m(x)*x^10 by g(x); the remainder fills the low 10 bits.
  function automatic logic [30:0] ref_cw(input logic [20:0] m);
    logic [30:0] r;
    logic [30:0] gp;
    r  = {m, 10'b0};
    gp = 31'h769;
    for (int i = 30; i >= 10; i--) begin
      if (r[i]) r = r ^ (gp << (i - 10));
    end
    return {m, r[9:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference model: per-encoder phase (0 idle, 1 encoding, 2 holding).
  int          phase  [N];
  int          left   [N];
  logic [30:0] exp_cw [N];
  bit          armed = 1'b0;

  initial begin
    for (int d = 0; d < N; d++) begin
      phase[d]  = 0;
      left[d]   = 0;
      exp_cw[d] = '0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < N; d++) begin
      logic exp_rdy;
      if (!rst) begin
        phase[d] = 0;
        left[d]  = 0;
      end
      exp_rdy = rst && armed && (phase[d] == 0);
      chk($sformatf("in_ready[%0d]", d),  32'(in_ready_a[d]),  32'(exp_rdy));
      chk($sformatf("out_valid[%0d]", d), 32'(out_valid_a[d]), 32'(phase[d] == 2));
      chk($sformatf("busy[%0d]", d),      32'(busy_a[d]),      32'(phase[d] != 0));
      if (!rst) chk($sformatf("rst_codeword[%0d]", d), 32'(codeword_a[d]), 32'h0);
      if (phase[d] == 2) chk($sformatf("codeword[%0d]", d), 32'(codeword_a[d]), 32'(exp_cw[d]));
      if (rst) begin
        case (phase[d])
          0: if (exp_rdy && in_valid) begin
               phase[d]  = 1;
               left[d]   = 21 / bpc(d);
               exp_cw[d] = ref_cw(message) ^ err_mask;
             end
          1: begin
               left[d]--;
               if (left[d] == 0) phase[d] = 2;
             end
          default: if (out_ready) phase[d] = 0;
        endcase
      end
    end
    armed = rst;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ordy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        2: out_ready = 1'b0;
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit all_ready();
    for (int d = 0; d < N; d++) if (!in_ready_a[d]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit all_valid();
    for (int d = 0; d < N; d++) if (!out_valid_a[d]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!all_ready()) begin
      tick();
      n++;
      if (n > 300) begin
        timeout_fail("wait_idle");
        return;
      end
    end
  endtask

  task automatic send(input logic [20:0] m, input logic [30:0] mk);
    message  = m;
    err_mask = mk;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    message  = 21'($urandom);
`ifdef BCH_ENC_ERR_INJECT_EN
    err_mask = 31'($urandom);
`endif
  endtask

  task automatic directed(input string name, input logic [20:0] m,
                          input logic [30:0] mk, input logic [30:0] expv);
    int n = 0;
    ordy_mode = 2;
    tick();
    wait_idle();
    send(m, mk);
    while (!all_valid()) begin
      tick();
      n++;
      if (n > 40) begin
        timeout_fail(name);
        break;
      end
    end
    for (int d = 0; d < N; d++) chk($sformatf("%s[%0d]", name, d), 32'(codeword_a[d]), 32'(expv));
    ordy_mode = 0;
    tick();
    wait_idle();
  endtask

  function automatic logic [30:0] rand_mask();
    logic [30:0] mk = '0;
`ifdef BCH_ENC_ERR_INJECT_EN
    int nb = $urandom_range(0, 3);
    for (int i = 0; i < nb; i++) mk[$urandom_range(0, 30)] = 1'b1;
`endif
    return mk;
  endfunction

  initial begin
    // Pin the model against hand-derived codewords.
    chk("model_0", 32'(ref_cw(21'h000000)), 32'h00000000);
    chk("model_1", 32'(ref_cw(21'h000001)), 32'h00000769);
    chk("model_2", 32'(ref_cw(21'h000002)), 32'h000009BB);
    chk("model_3", 32'(ref_cw(21'h000003)), 32'h00000ED2);

    repeat (3) tick();
    for (int d = 0; d < N; d++) begin
      chk($sformatf("reset_in_ready[%0d]", d), 32'(in_ready_a[d]), 32'h0);
      chk($sformatf("reset_cw[%0d]", d), 32'(codeword_a[d]), 32'h0);
    end
    rst = 1'b1;
    ordy_mode = 0;
    tick();
    wait_idle();

    directed("zero_msg", 21'h000000, 31'h0, 31'h00000000);
    directed("msg1",     21'h000001, 31'h0, 31'h00000769);
    directed("msg2",     21'h000002, 31'h0, 31'h000009BB);
    directed("msg3",     21'h000003, 31'h0, 31'h00000ED2);
    directed("msg_top",  21'h100000, 31'h0, ref_cw(21'h100000));
    directed("msg_ones", 21'h1FFFFF, 31'h0, ref_cw(21'h1FFFFF));

    // Long HOLD with a competing in_valid that must be ignored.
    ordy_mode = 2;
    tick();
    wait_idle();
    send(21'($urandom), 31'h0);
    for (int c = 0; c < 50; c++) begin
      if (c >= 25 && c < 40) begin
        in_valid = 1'b1;
        message  = 21'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    for (int d = 0; d < N; d++) begin
      chk($sformatf("hold_ovld[%0d]", d), 32'(out_valid_a[d]), 32'h1);
      chk($sformatf("hold_irdy[%0d]", d), 32'(in_ready_a[d]), 32'h0);
    end
    ordy_mode = 3;
    out_ready = 1'b1;
    tick();
    for (int d = 0; d < N; d++)
      chk($sformatf("hold_release_irdy[%0d]", d), 32'(in_ready_a[d]), 32'h1);
    ordy_mode = 0;
    tick();
    wait_idle();

    // Reset while the 1-bit encoder is at count 10 (others already holding).
    ordy_mode = 2;
    tick();
    wait_idle();
    send(21'($urandom), 31'h0);
    repeat (10) tick();
    rst = 1'b0;
    #1;
    for (int d = 0; d < N; d++) begin
      chk($sformatf("midrst_ovld[%0d]", d), 32'(out_valid_a[d]), 32'h0);
      chk($sformatf("midrst_busy[%0d]", d), 32'(busy_a[d]), 32'h0);
    end
    tick();
    tick();
    rst = 1'b1;
    ordy_mode = 0;
    tick();
    wait_idle();
    directed("post_rst_msg1", 21'h000001, 31'h0, 31'h00000769);

`ifdef BCH_ENC_ERR_INJECT_EN
    directed("err_inject", 21'h000001, 31'h40000001, 31'h40000768);
`endif

    // Randomized traffic with random output backpressure.
    ordy_mode = 1;
    for (int i = 0; i < 350; i++) begin
      wait_idle();
      repeat ($urandom_range(0, 2)) tick();
      send(21'($urandom), rand_mask());
    end
    ordy_mode = 0;
    tick();
    wait_idle();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
